sub_seq_ctrl: RTL and testbench
===============================

# sub_seq_ctrl

Multi-cycle sequencer that computes a wide unsigned/two's-complement difference A − B by reusing a single 4-bit subtract slice once per nibble, LSB nibble first. The slice computes a + ~b + cin, with carry-out meaning "no borrow". The borrow chain is carried between cycles in a register. The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It is the controller that lets the existing 4-bit subtractor datapath serve word-wide operands.

## Interface
Parameters:
- NIBBLES, default 4: number of 4-bit slices per operand. Operand width W = 4*NIBBLES. Legal range 1..8.

Ports:
- clk  input  1  rising-edge clock; one clock domain.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand pair a/b is presented.
- in_ready  output  1  block can accept operands.
- a  input  W  minuend.
- b  input  W  subtrahend.
- out_valid  output  1  diff/carry hold a completed result.
- out_ready  input  1  consumer accepts the result.
- diff  output  W  A − B modulo 2^W.
- carry  output  1  final slice carry-out. 1 = no borrow (A ≥ B unsigned); 0 = borrow.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a→a_q and b→b_q, set nib_cnt = 0 and borrow register c = 1 (initial cin = 1), then go to RUN.
  - in_valid alone while not IDLE is ignored. The producer must hold a/b until accepted.
- RUN, one nibble per cycle:
  - Compute {c_out, s} = a_q[4i+3:4i] + ~b_q[4i+3:4i] + c (5-bit sum), where i = nib_cnt.
  - Register s into diff[4i+3:4i] and c_out into c, then increment nib_cnt.
  - When nib_cnt == NIBBLES−1, the update is the last one: carry <= c_out, go to DONE.
- DONE:
  - out_valid = 1.
  - diff and carry are held stable until out_ready = 1.
  - On out_valid & out_ready: go to IDLE next edge; out_valid drops.
- in_ready is combinational from state (state == IDLE). All other outputs are registered.
- Arithmetic: all sums are mod 16 per slice; diff wraps mod 2^W. Signed interpretation is the consumer's concern; no overflow flag.
- diff bits may change during RUN. They are defined only while out_valid = 1.

## Timing
- Reset: any edge with rst_n = 0 forces IDLE, out_valid = 0, diff = 0, carry = 0, busy = 0, nib_cnt = 0, c = 1. in_ready = 1 from the first cycle after the reset edge.
- Reset mid-RUN or mid-DONE: the operation is discarded with no result. out_valid is 0 in the cycle after the reset edge.
- Latency: operands accepted at edge k → out_valid = 1 in the cycle after edge k+NIBBLES.
- DONE with out_ready = 1 → IDLE after one edge. The next accept edge is at the earliest one edge later.
- Minimum issue interval: NIBBLES+2 cycles.
- out_ready held 1 before DONE: the result is consumed on the first DONE cycle, so out_valid is high exactly 1 cycle.
- Backpressure: out_ready = 0 keeps DONE indefinitely. in_ready stays 0 throughout.
- NIBBLES = 1: RUN lasts 1 cycle; the same rules apply.

## Test plan
(NIBBLES = 4)
- Reset release: hold rst_n = 0 for 3 edges, then release → out_valid = 0, diff = 0x0000, carry = 0, busy = 0, in_ready = 1.
- Basic results, out_ready tied 1:
  - 0x1234 − 0x0234 → diff = 0x1000, carry = 1.
  - 0xABCD − 0xABCD → diff = 0x0000, carry = 1.
  - out_valid rises exactly 4 cycles after the accept edge.
- Borrow ripple:
  - 0x0100 − 0x0001 → 0x00FF, carry = 1.
  - 0x0000 − 0x0001 → 0xFFFF, carry = 0.
  - 0xFFFF − 0x8000 → 0x7FFF, carry = 1.
- Backpressure: result 0x0003 − 0x0005 (= 0xFFFE, carry = 0) with out_ready = 0 for 5 cycles → diff/carry stable, out_valid = 1, in_ready = 0. A new in_valid in that window is not accepted. Raising out_ready → IDLE next edge.
- Reset mid-operation: assert rst_n = 0 for one edge after 2 RUN cycles of 0x5555 − 0x1111 → IDLE, out_valid never asserts for that operation. Next op 0x0010 − 0x0001 → 0x000F, carry = 1.
- Back-to-back: in_valid held high with 3 queued operand pairs and out_ready = 1 → results in order, with accept edges exactly 6 cycles apart.

Source files
------------

// File: rtl/sub_seq_ctrl.sv
// sub_seq_ctrl: word-wide subtract A - B using one 4-bit slice per cycle.
// LSB nibble first; the borrow chain is kept in a register between cycles.
module sub_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   diff,
    output logic                   carry,
    output logic                   busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [CW-1:0]   nib_cnt;
    logic            c;
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [4:0]      sum;
    logic            last;
    logic            accept;
    logic            consume;
    logic            out_valid_nx;
    logic            busy_nx;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid & out_ready;
    assign last     = (nib_cnt == LAST);

    // Select the operand nibbles addressed by the slice counter.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (nib_cnt == CW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    // The shared 4-bit slice: a + ~b + cin, carry-out means no borrow.
    always_comb begin
        sum = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0, c};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (consume) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flags can be registered.
    always_comb begin
        out_valid_nx = (state_nx == DONE);
        busy_nx      = (state_nx != IDLE);
    end

    // Registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= out_valid_nx;
            busy      <= busy_nx;
        end
    end

    // Operand capture, per-nibble result write and borrow chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            nib_cnt <= '0;
            c       <= 1'b1;
            diff    <= '0;
            carry   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b;
                        nib_cnt <= '0;
                        c       <= 1'b1;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (nib_cnt == CW'(i)) begin
                            diff[4*i +: 4] <= sum[3:0];
                        end
                    end
                    c       <= sum[4];
                    nib_cnt <= nib_cnt + 1'b1;
                    if (last) begin
                        carry <= sum[4];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// tb_sub_seq_ctrl: directed stimulus for sub_seq_ctrl (NIBBLES = 4)
// with a per-cycle transaction-level reference and literal checks.
module tb_sub_seq_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         carry;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;
    int tcyc   = 0;

    sub_seq_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .carry     (carry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Reference: one outstanding transaction; result visible N edges
    // after acceptance, retired on the edge where the consumer takes it.
    bit           armed   = 1'b0;
    bit           pending = 1'b0;
    int           age     = 0;
    logic [W-1:0] m_d     = '0;
    logic         m_c     = 1'b0;
    logic         exp_v;

    always @(negedge clk) begin
        if (armed) begin
            exp_v = pending && (age >= N);
            chk("in_ready", 32'(in_ready), 32'(!pending));
            chk("busy", 32'(busy), 32'(pending));
            chk("out_valid", 32'(out_valid), 32'(exp_v));
            if (exp_v) begin
                chk("model_diff", 32'(diff), 32'(m_d));
                chk("model_carry", 32'(carry), 32'(m_c));
            end
        end
        if (!rst_n) begin
            pending = 1'b0;
            armed   = 1'b1;
        end else if (pending) begin
            if (age >= N && out_ready) begin
                pending = 1'b0;
            end else begin
                age++;
            end
        end else if (in_valid) begin
            pending = 1'b1;
            age     = 0;
            m_d     = a - b;
            m_c     = (a >= b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        tcyc++;
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) timeout("accept");
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        if (!out_valid) timeout("out_valid");
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ed, input logic ec);
        int lat;
        issue(x, y);
        wait_done(lat);
        chk("latency", 32'(lat), 32'd4);
        chk("diff", 32'(diff), 32'(ed));
        chk("carry", 32'(carry), 32'(ec));
        step();
        chk("drop_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int t[3];
        logic [W-1:0] pa[3];
        logic [W-1:0] pb[3];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        run_op(16'h1234, 16'h0234, 16'h1000, 1'b1);
        run_op(16'hABCD, 16'hABCD, 16'h0000, 1'b1);
        run_op(16'h0100, 16'h0001, 16'h00FF, 1'b1);
        run_op(16'h0000, 16'h0001, 16'hFFFF, 1'b0);
        run_op(16'hFFFF, 16'h8000, 16'h7FFF, 1'b1);

        // Backpressure with a competing request in the stall window.
        out_ready = 1'b0;
        issue(16'h0003, 16'h0005);
        wait_done(lat);
        chk("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            a        = 16'h9999;
            b        = 16'h0001;
            in_valid = 1'b1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_diff", 32'(diff), 32'h0000FFFE);
            chk("bp_carry", 32'(carry), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        in_valid  = 1'b0;
        chk("bp_hold_diff", 32'(diff), 32'h0000FFFE);
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);

        // Reset after two RUN cycles discards the operation.
        issue(16'h5555, 16'h1111);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid_rst_no_result", 32'(out_valid), 32'd0);
        end
        run_op(16'h0010, 16'h0001, 16'h000F, 1'b1);

        // Back-to-back with in_valid held high.
        pa[0] = 16'h8000; pb[0] = 16'h0001;
        pa[1] = 16'h0001; pb[1] = 16'h8000;
        pa[2] = 16'h1111; pb[2] = 16'h2222;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = pa[i];
            b = pb[i];
            n = 0;
            while (!in_ready && n < 50) begin
                step();
                n++;
            end
            if (!in_ready) timeout("b2b_accept");
            step();
            t[i] = tcyc;
        end
        in_valid = 1'b0;
        wait_done(lat);
        chk("b2b_last_diff", 32'(diff), 32'h0000EEEF);
        chk("b2b_last_carry", 32'(carry), 32'd0);
        step();
        chk("b2b_gap01", 32'(t[1] - t[0]), 32'd6);
        chk("b2b_gap12", 32'(t[2] - t[1]), 32'd6);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
